// File: rtl/wb_bus_master_pkg.sv
// wb_bus_master_pkg: shared codes, slave selects and FSM state encoding for the Wishbone bus master.
package wb_bus_master_pkg;
  localparam logic RstEnable = 1'b1;
  localparam logic ChipEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam int WbTimeoutDefault = 255;
  localparam logic [15:0] WB_SELECT_ZERO = 16'h0000;
  localparam logic [15:0] WB_SELECT_RAM = 16'h0001;
  localparam logic [15:0] WB_SELECT_ROM = 16'h0002;
  localparam logic [15:0] WB_SELECT_FLASH = 16'h0004;
  localparam logic [15:0] WB_SELECT_UART = 16'h0008;
  localparam logic [15:0] WB_SELECT_UART_STAT = 16'h0010;
  localparam logic [15:0] WB_SELECT_DIGSEG = 16'h0020;
  localparam logic [15:0] WB_SELECT_PS2 = 16'h0040;
  localparam logic [15:0] WB_SELECT_MAPPED = WB_SELECT_RAM | WB_SELECT_ROM | WB_SELECT_FLASH |
    WB_SELECT_UART | WB_SELECT_UART_STAT | WB_SELECT_DIGSEG | WB_SELECT_PS2;
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_BUSY = 2'd1,
    WB_WAIT_STALL = 2'd2
  } wb_state_e;
  function automatic logic wb_mapped(input logic [15:0] s);
    return |(s & WB_SELECT_MAPPED);
  endfunction
endpackage

// File: rtl/wb_bus_master_timeout_cnt.sv
// wb_timeout_cnt: counts BUSY cycles without ack and flags the last allowed one.
module wb_timeout_cnt #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign expired = cnt == CNT_W'(LIMIT - 1);
endmodule

// File: rtl/wb_bus_master.sv
// wb_bus_master: runs one Wishbone classic access per translated CPU request, stalling until ack.
module wb_bus_master
  import wb_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WbTimeoutDefault,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  input  logic [15:0] tlb_select_i,
  input  logic        tlb_exc_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  output logic [15:0] wb_slave_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);
  wb_state_e state, state_nxt;
  logic [31:0] rd_buf;
  logic accept, start, unmapped, busy, ack, tmo, expired, mem_stall;
  logic unused_stall;
  assign unused_stall = ^{stall_i[5:4], stall_i[2:0]};
  assign mem_stall = stall_i[3];
  assign accept = state == WB_IDLE && cpu_ce_i == ChipEnable && !flush_i && !tlb_exc_i;
  assign start = accept && wb_mapped(tlb_select_i);
  assign unmapped = accept && !wb_mapped(tlb_select_i);
  assign busy = state == WB_BUSY;
  assign ack = busy && !flush_i && wb_ack_i;
  assign tmo = busy && !flush_i && !wb_ack_i && expired;
  wb_timeout_cnt #(.CNT_W(CNT_W), .LIMIT(TIMEOUT_CYCLES)) u_cnt (
    .clk(clk), .rst(rst), .clr(start), .en(busy && !wb_ack_i && !flush_i), .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (rst == RstEnable) state <= WB_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      WB_IDLE: state_nxt = start ? WB_BUSY : WB_IDLE;
      WB_BUSY: state_nxt = flush_i ? WB_IDLE : wb_ack_i ? (mem_stall ? WB_WAIT_STALL : WB_IDLE) :
                           expired ? WB_IDLE : WB_BUSY;
      WB_WAIT_STALL: state_nxt = (!mem_stall || flush_i) ? WB_IDLE : WB_WAIT_STALL;
      default: state_nxt = WB_IDLE;
    endcase
  end
  always_comb begin
    stallreq_o = start || (busy && !wb_ack_i);
    cpu_data_o = ack ? wb_dat_i : state == WB_WAIT_STALL ? rd_buf : ZeroWord;
  end
  // Bus signals are registered so they hold steady for the whole BUSY phase.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      {wb_cyc_o, wb_stb_o, wb_we_o, bus_err_o} <= '0;
      wb_adr_o <= ZeroWord;
      wb_sel_o <= '0;
      wb_dat_o <= ZeroWord;
      wb_slave_o <= WB_SELECT_ZERO;
      rd_buf <= ZeroWord;
    end else begin
      bus_err_o <= unmapped || tmo;
      if (start) begin
        {wb_cyc_o, wb_stb_o} <= 2'b11;
        wb_we_o <= cpu_we_i;
        wb_adr_o <= cpu_addr_i;
        wb_sel_o <= cpu_sel_i;
        wb_dat_o <= cpu_data_i;
        wb_slave_o <= tlb_select_i;
      end else if (busy && (flush_i || wb_ack_i || expired)) begin
        {wb_cyc_o, wb_stb_o} <= 2'b00;
      end
      if (ack) rd_buf <= wb_dat_i;
      else if (tmo) rd_buf <= ZeroWord;
    end
  end
endmodule

// File: tb/tb_wb_bus_master.sv
// tb_wb_bus_master: directed vector table plus hand sequences for timeout, flush and reset.
module tb_wb_bus_master;
  import wb_bus_master_pkg::*;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, cpu_ce_i, cpu_we_i, tlb_exc_i, flush_i, wb_ack_i;
  logic [31:0] cpu_addr_i, cpu_data_i, wb_dat_i;
  logic [3:0] cpu_sel_i;
  logic [15:0] tlb_select_i;
  logic [5:0] stall_i;
  logic [31:0] cpu_data_o, wb_adr_o, wb_dat_o;
  logic stallreq_o, bus_err_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0] wb_sel_o;
  logic [15:0] wb_slave_o;
  wb_bus_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .tlb_select_i(tlb_select_i),
    .tlb_exc_i(tlb_exc_i), .stall_i(stall_i), .flush_i(flush_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_slave_o(wb_slave_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );
  typedef struct {
    logic ce, exc, st3, ack;
    logic [31:0] addr;
    logic [15:0] tsel;
    logic [31:0] rdat;
    logic e_stall, e_err, e_cyc;
    logic [31:0] e_data;
  } vec_t;
  vec_t q[$];
  int total = 0;
  int bad = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic add(input logic ce, exc, st3, ack, input logic [31:0] addr,
                     input logic [15:0] tsel, input logic [31:0] rdat,
                     input logic es, ee, ec, input logic [31:0] ed);
    q.push_back('{ce, exc, st3, ack, addr, tsel, rdat, es, ee, ec, ed});
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic idle();
    {cpu_ce_i, cpu_we_i, tlb_exc_i, flush_i, wb_ack_i} = '0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    wb_dat_i = '0;
    cpu_sel_i = 4'hf;
    tlb_select_i = WB_SELECT_ZERO;
    stall_i = '0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    idle();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
    smp();
    chk("rst_cyc", 32'(wb_cyc_o), 0);
    chk("rst_stb", 32'(wb_stb_o), 0);
    chk("rst_err", 32'(bus_err_o), 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_slave", 32'(wb_slave_o), 0);
    chk("rst_data", cpu_data_o, 0);
    nxt();
    // RAM read, ack in the third BUSY cycle
    add(H, L, L, L, 32'h10, WB_SELECT_RAM, 0, H, L, L, 0);
    add(H, L, L, L, 32'h10, WB_SELECT_RAM, 0, H, L, H, 0);
    add(H, L, L, L, 32'h10, WB_SELECT_RAM, 0, H, L, H, 0);
    add(H, L, L, H, 32'h10, WB_SELECT_RAM, 32'hDEADBEEF, L, L, H, 32'hDEADBEEF);
    add(L, L, L, L, 0, WB_SELECT_ZERO, 0, L, L, L, 0);
    // unmapped access
    add(H, L, L, L, 32'h30000000, WB_SELECT_ZERO, 0, L, L, L, 0);
    add(L, L, L, L, 0, WB_SELECT_ZERO, 0, L, H, L, 0);
    add(L, L, L, L, 0, WB_SELECT_ZERO, 0, L, L, L, 0);
    // ack while MEM stalled; data held, no new access until release
    add(H, L, L, L, 32'h20, WB_SELECT_RAM, 0, H, L, L, 0);
    add(H, L, H, H, 32'h20, WB_SELECT_RAM, 32'hCAFEF00D, L, L, H, 32'hCAFEF00D);
    add(H, L, H, L, 32'h24, WB_SELECT_RAM, 0, L, L, L, 32'hCAFEF00D);
    add(H, L, H, L, 32'h24, WB_SELECT_RAM, 0, L, L, L, 32'hCAFEF00D);
    add(H, L, H, L, 32'h24, WB_SELECT_RAM, 0, L, L, L, 32'hCAFEF00D);
    add(H, L, L, L, 32'h24, WB_SELECT_RAM, 0, L, L, L, 32'hCAFEF00D);
    add(H, L, L, L, 32'h24, WB_SELECT_RAM, 0, H, L, L, 0);
    add(H, L, L, H, 32'h24, WB_SELECT_RAM, 32'h12345678, L, L, H, 32'h12345678);
    add(L, L, L, L, 0, WB_SELECT_ZERO, 0, L, L, L, 0);
    // TLB exception suppresses access; stray ack is ignored
    add(H, H, L, L, 32'h28, WB_SELECT_RAM, 0, L, L, L, 0);
    add(L, L, L, H, 0, WB_SELECT_ZERO, 32'hFFFFFFFF, L, L, L, 0);
    for (int i = 0; i < q.size(); i++) begin
      cpu_ce_i = q[i].ce;
      tlb_exc_i = q[i].exc;
      stall_i = {2'b00, q[i].st3, 3'b000};
      wb_ack_i = q[i].ack;
      cpu_addr_i = q[i].addr;
      tlb_select_i = q[i].tsel;
      wb_dat_i = q[i].rdat;
      smp();
      chk($sformatf("v%0d_stall", i), 32'(stallreq_o), 32'(q[i].e_stall));
      chk($sformatf("v%0d_err", i), 32'(bus_err_o), 32'(q[i].e_err));
      chk($sformatf("v%0d_cyc", i), 32'(wb_cyc_o), 32'(q[i].e_cyc));
      chk($sformatf("v%0d_data", i), cpu_data_o, q[i].e_data);
      nxt();
    end
    // UART write
    idle();
    cpu_ce_i = 1'b1;
    cpu_we_i = 1'b1;
    cpu_addr_i = 32'h1fd003f8;
    cpu_data_i = 32'h41;
    cpu_sel_i = 4'b0001;
    tlb_select_i = WB_SELECT_UART;
    smp();
    chk("uart_req_stall", 32'(stallreq_o), 1);
    nxt();
    wb_ack_i = 1'b1;
    smp();
    chk("uart_cyc", 32'(wb_cyc_o), 1);
    chk("uart_stb", 32'(wb_stb_o), 1);
    chk("uart_we", 32'(wb_we_o), 1);
    chk("uart_adr", wb_adr_o, 32'h1fd003f8);
    chk("uart_dat", wb_dat_o, 32'h41);
    chk("uart_sel", 32'(wb_sel_o), 1);
    chk("uart_slave", 32'(wb_slave_o), 32'(WB_SELECT_UART));
    chk("uart_ack_stall", 32'(stallreq_o), 0);
    nxt();
    idle();
    smp();
    chk("uart_end_cyc", 32'(wb_cyc_o), 0);
    nxt();
    // timeout: slave never acks
    cpu_ce_i = 1'b1;
    cpu_addr_i = 32'h40;
    tlb_select_i = WB_SELECT_RAM;
    smp();
    chk("to_req_stall", 32'(stallreq_o), 1);
    nxt();
    for (int i = 0; i < 8; i++) begin
      smp();
      chk($sformatf("to_busy%0d_cyc", i), 32'(wb_cyc_o), 1);
      chk($sformatf("to_busy%0d_stall", i), 32'(stallreq_o), 1);
      chk($sformatf("to_busy%0d_err", i), 32'(bus_err_o), 0);
      nxt();
    end
    idle();
    smp();
    chk("to_cyc", 32'(wb_cyc_o), 0);
    chk("to_err", 32'(bus_err_o), 1);
    chk("to_stall", 32'(stallreq_o), 0);
    chk("to_data", cpu_data_o, 0);
    nxt();
    smp();
    chk("to_err_clear", 32'(bus_err_o), 0);
    nxt();
    // flush in BUSY, then late ack
    cpu_ce_i = 1'b1;
    cpu_addr_i = 32'h50;
    tlb_select_i = WB_SELECT_RAM;
    nxt();
    smp();
    chk("fl_busy_cyc", 32'(wb_cyc_o), 1);
    nxt();
    flush_i = 1'b1;
    nxt();
    idle();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hBAD0BAD0;
    smp();
    chk("fl_cyc", 32'(wb_cyc_o), 0);
    chk("fl_stb", 32'(wb_stb_o), 0);
    chk("fl_data", cpu_data_o, 0);
    chk("fl_err", 32'(bus_err_o), 0);
    chk("fl_stall", 32'(stallreq_o), 0);
    nxt();
    wb_ack_i = 1'b0;
    smp();
    chk("fl_err2", 32'(bus_err_o), 0);
    nxt();
    // reset in BUSY, then late ack
    cpu_ce_i = 1'b1;
    cpu_addr_i = 32'h60;
    tlb_select_i = WB_SELECT_ROM;
    nxt();
    smp();
    chk("rb_busy_cyc", 32'(wb_cyc_o), 1);
    nxt();
    rst = 1'b1;
    cpu_ce_i = 1'b0;
    nxt();
    rst = 1'b0;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h5555AAAA;
    smp();
    chk("rb_cyc", 32'(wb_cyc_o), 0);
    chk("rb_data", cpu_data_o, 0);
    chk("rb_err", 32'(bus_err_o), 0);
    chk("rb_slave", 32'(wb_slave_o), 0);
    nxt();
    idle();
    smp();
    chk("rb_err2", 32'(bus_err_o), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
